// File: rtl/trdb_ctrl_regs.sv
// Trace encoder control/status register block: per-channel CTRL/STATUS/ON_COUNT
// registers behind a single-cycle bus, plus a trace-enable FSM with a drain window.
module trdb_ctrl_regs #(
    parameter int NCH          = 2,
    parameter int ADDR_W       = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    input  logic [NCH-1:0]    trace_req_on_i,
    input  logic [NCH-1:0]    trace_req_off_i,
    output logic [NCH-1:0]    trace_enable_o,
    output logic [NCH-1:0]    trace_activated_o,
    output logic [NCH-1:0]    clk_en_o,
    output logic [NCH-1:0]    nocontext_o,
    output logic [NCH-1:0]    notime_o,
    output logic [NCH-1:0]    delta_address_o,
    output logic [NCH-1:0]    full_address_o,
    output logic              encoder_mode_o
);

    localparam int CHW  = ADDR_W - 4;
    localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CNTW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNTW-1:0] DRAIN_LOAD = CNTW'(DRAIN_CYCLES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_TRACING = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    logic [CHW-1:0]  w_chan;
    logic [1:0]      w_reg;
    logic [IDXW-1:0] w_idx;
    logic            w_err;
    logic [31:0]     w_rd;
    logic [31:0]     w_ctrl_rd   [NCH];
    logic [31:0]     w_status_rd [NCH];
    logic [31:0]     w_count_rd  [NCH];
    logic            w_unused;

    assign w_chan   = addr_i[ADDR_W-1:4];
    assign w_reg    = addr_i[3:2];
    assign w_idx    = w_chan[IDXW-1:0];
    assign w_err    = ({1'b0, w_chan} >= (CHW+1)'(NCH)) || (w_reg == 2'd3);
    assign w_unused = ^{addr_i[1:0], wdata_i[31:6]};

    assign encoder_mode_o = 1'b0;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic            w_sel, w_wr_ctrl, w_wr_stat, w_wr_cnt;
        logic            w_on_eff, w_off, w_start;
        logic            r_activate, r_nocontext, r_notime, r_delta, r_full;
        logic            r_on_seen, r_off_seen;
        logic [1:0]      r_state;
        logic [CNTW-1:0] r_drain;
        logic [15:0]     r_on_count;

        assign w_sel     = req_i & ~w_err & (w_idx == IDXW'(c));
        assign w_wr_ctrl = w_sel & we_i & (w_reg == 2'd0);
        assign w_wr_stat = w_sel & we_i & (w_reg == 2'd1);
        assign w_wr_cnt  = w_sel & we_i & (w_reg == 2'd2);
        // A CTRL write with bit1 set acts as a software trigger in that same cycle.
        assign w_on_eff  = trace_req_on_i[c] | (w_wr_ctrl & wdata_i[1]);
        assign w_off     = trace_req_off_i[c];
        assign w_start   = (r_state == S_ARMED) & r_activate & w_on_eff & ~w_off;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_activate  <= 1'b1;
                r_nocontext <= 1'b1;
                r_notime    <= 1'b1;
                r_delta     <= 1'b1;
                r_full      <= 1'b0;
            end else if (w_wr_ctrl) begin
                r_activate  <= wdata_i[0];
                r_nocontext <= wdata_i[2];
                r_notime    <= wdata_i[3];
                r_delta     <= wdata_i[4];
                r_full      <= wdata_i[5];
            end
        end

        // The FSM sees the CTRL value from before any write landing this cycle.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_state <= S_IDLE;
                r_drain <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_activate) r_state <= S_ARMED;
                    end
                    S_ARMED: begin
                        if (!r_activate)  r_state <= S_IDLE;
                        else if (w_start) r_state <= S_TRACING;
                    end
                    S_TRACING: begin
                        if (w_off || !r_activate) begin
                            r_state <= S_DRAIN;
                            r_drain <= DRAIN_LOAD;
                        end
                    end
                    default: begin
                        if (r_drain == '0) r_state <= r_activate ? S_ARMED : S_IDLE;
                        else               r_drain <= r_drain - 1'b1;
                    end
                endcase
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_on_seen  <= 1'b0;
                r_off_seen <= 1'b0;
                r_on_count <= '0;
            end else begin
                r_on_seen  <= w_on_eff | (r_on_seen  & ~(w_wr_stat & wdata_i[2]));
                r_off_seen <= w_off    | (r_off_seen & ~(w_wr_stat & wdata_i[3]));
                if (w_wr_cnt)
                    r_on_count <= '0;
                else if (w_start && (r_on_count != 16'hFFFF))
                    r_on_count <= r_on_count + 16'd1;
            end
        end

        assign w_ctrl_rd[c]   = {26'd0, r_full, r_delta, r_notime, r_nocontext, 1'b0, r_activate};
        assign w_status_rd[c] = {28'd0, r_off_seen, r_on_seen, r_state};
        assign w_count_rd[c]  = {16'd0, r_on_count};

        assign trace_enable_o[c]    = (r_state == S_TRACING);
        assign clk_en_o[c]          = (r_state != S_IDLE);
        assign trace_activated_o[c] = r_activate;
        assign nocontext_o[c]       = r_nocontext;
        assign notime_o[c]          = r_notime;
        assign delta_address_o[c]   = r_delta & ~r_full;
        assign full_address_o[c]    = r_full;
    end

    always_comb begin
        w_rd = '0;
        if (req_i && !we_i && !w_err) begin
            case (w_reg)
                2'd0:    w_rd = w_ctrl_rd[w_idx];
                2'd1:    w_rd = w_status_rd[w_idx];
                2'd2:    w_rd = w_count_rd[w_idx];
                default: w_rd = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= req_i;
            err_o    <= req_i & w_err;
            rdata_o  <= w_rd;
        end
    end

endmodule

// File: tb/tb_trdb_ctrl_regs.sv
// Directed bench for trdb_ctrl_regs: bus responses are checked by a scoreboard
// monitor, FSM/config pins are checked inline against hand-computed values.
module tb_trdb_ctrl_regs;

    localparam int NCH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic        rvalid, err;
    logic [31:0] rdata;
    logic [1:0]  onReq = '0, offReq = '0;
    logic [1:0]  traceEnable, traceActivated, clkEn, noContext, noTime, deltaAddr, fullAddr;
    logic        encoderMode;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t expQ[$];
    exp_t expHead;
    int   cyc = 0;
    int   checkCount = 0;
    int   errorCount = 0;

    trdb_ctrl_regs #(.NCH(NCH), .ADDR_W(8), .DRAIN_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
        .trace_req_on_i(onReq), .trace_req_off_i(offReq),
        .trace_enable_o(traceEnable), .trace_activated_o(traceActivated), .clk_en_o(clkEn),
        .nocontext_o(noContext), .notime_o(noTime), .delta_address_o(deltaAddr),
        .full_address_o(fullAddr), .encoder_mode_o(encoderMode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Each expected response is due on a specific cycle; anything early, late or extra is an error.
    always @(negedge clk) begin
        if (expQ.size() > 0 && expQ[0].due == cyc) begin
            expHead = expQ.pop_front();
            checkOutput("bus rvalid", 32'(rvalid), 32'd1);
            checkOutput("bus rdata", rdata, expHead.data);
            checkOutput("bus err", 32'(err), 32'(expHead.err));
        end else if (rvalid !== 1'b0) begin
            checkOutput("bus spurious rvalid", 32'(rvalid), 32'd0);
        end
    end

    task automatic applyStimulus(input logic w, input logic [7:0] a, input logic [31:0] d,
                                 input logic [31:0] expData, input logic expErr);
        req = 1'b1; we = w; addr = a; wdata = d;
        expQ.push_back('{expData, expErr, cyc + 1});
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse(input logic [1:0] on, input logic [1:0] off);
        onReq = on; offReq = off;
        step(1);
        onReq = '0; offReq = '0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset rvalid", 32'(rvalid), 32'd0);
        checkOutput("reset rdata", rdata, 32'd0);
        checkOutput("reset err", 32'(err), 32'd0);
        checkOutput("reset trace_enable", 32'(traceEnable), 32'd0);
        checkOutput("reset clk_en", 32'(clkEn), 32'd0);
        checkOutput("reset activated", 32'(traceActivated), 32'h3);
        checkOutput("reset nocontext", 32'(noContext), 32'h3);
        checkOutput("reset notime", 32'(noTime), 32'h3);
        checkOutput("reset delta", 32'(deltaAddr), 32'h3);
        checkOutput("reset full", 32'(fullAddr), 32'h0);
        checkOutput("encoder_mode", 32'(encoderMode), 32'h0);
        rst = 1'b0;

        applyStimulus(1'b0, 8'h00, 0, 32'h1D, 1'b0);
        applyStimulus(1'b0, 8'h04, 0, 32'h1, 1'b0);
        checkOutput("armed clk_en", 32'(clkEn), 32'h3);

        // Trigger start on channel 0
        pulse(2'b01, 2'b00);
        checkOutput("start trace_enable", 32'(traceEnable), 32'h1);
        applyStimulus(1'b0, 8'h08, 0, 32'h1, 1'b0);
        applyStimulus(1'b0, 8'h04, 0, 32'h6, 1'b0);
        applyStimulus(1'b1, 8'h04, 32'h4, 32'h0, 1'b0);
        applyStimulus(1'b0, 8'h04, 0, 32'h2, 1'b0);
        applyStimulus(1'b0, 8'h18, 0, 32'h0, 1'b0);

        // Stop and drain window
        pulse(2'b00, 2'b01);
        checkOutput("stop trace_enable", 32'(traceEnable), 32'h0);
        checkOutput("drain clk_en t+1", 32'(clkEn[0]), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step(1);
            checkOutput("drain clk_en", 32'(clkEn[0]), 32'h1);
        end
        applyStimulus(1'b0, 8'h04, 0, 32'hB, 1'b0);
        applyStimulus(1'b0, 8'h04, 0, 32'h9, 1'b0);
        applyStimulus(1'b1, 8'h04, 32'h8, 32'h0, 1'b0);
        applyStimulus(1'b0, 8'h04, 0, 32'h1, 1'b0);

        // Simultaneous on/off in ARMED, then in TRACING
        pulse(2'b01, 2'b01);
        checkOutput("on+off armed trace_enable", 32'(traceEnable), 32'h0);
        applyStimulus(1'b0, 8'h04, 0, 32'hD, 1'b0);
        applyStimulus(1'b1, 8'h04, 32'hC, 32'h0, 1'b0);
        pulse(2'b01, 2'b00);
        checkOutput("restart trace_enable", 32'(traceEnable), 32'h1);
        pulse(2'b01, 2'b01);
        checkOutput("on+off tracing trace_enable", 32'(traceEnable), 32'h0);
        applyStimulus(1'b0, 8'h04, 0, 32'hF, 1'b0);
        step(3);
        applyStimulus(1'b0, 8'h04, 0, 32'hD, 1'b0);
        applyStimulus(1'b1, 8'h04, 32'hC, 32'h0, 1'b0);
        applyStimulus(1'b0, 8'h08, 0, 32'h2, 1'b0);

        // Deactivate while tracing: drains then goes idle
        pulse(2'b01, 2'b00);
        applyStimulus(1'b1, 8'h00, 32'h30, 32'h0, 1'b0);
        checkOutput("deact still tracing", 32'(traceEnable), 32'h1);
        checkOutput("deact full", 32'(fullAddr), 32'h1);
        checkOutput("deact delta", 32'(deltaAddr), 32'h2);
        checkOutput("deact nocontext", 32'(noContext), 32'h2);
        checkOutput("deact notime", 32'(noTime), 32'h2);
        checkOutput("deact activated", 32'(traceActivated), 32'h2);
        for (int i = 0; i < 4; i++) begin
            step(1);
            checkOutput("deact drain clk_en", 32'(clkEn[0]), 32'h1);
            checkOutput("deact drain trace_enable", 32'(traceEnable[0]), 32'h0);
        end
        step(1);
        checkOutput("idle clk_en", 32'(clkEn), 32'h2);
        applyStimulus(1'b0, 8'h04, 0, 32'h4, 1'b0);
        applyStimulus(1'b0, 8'h00, 0, 32'h30, 1'b0);

        // Error accesses have no effect
        applyStimulus(1'b1, 8'h20, 32'h1, 32'h0, 1'b1);
        applyStimulus(1'b0, 8'h20, 0, 32'h0, 1'b1);
        applyStimulus(1'b0, 8'h0C, 0, 32'h0, 1'b1);
        applyStimulus(1'b1, 8'h1C, 32'hFFFF_FFFF, 32'h0, 1'b1);
        applyStimulus(1'b0, 8'h24, 0, 32'h0, 1'b1);
        applyStimulus(1'b0, 8'h00, 0, 32'h30, 1'b0);
        applyStimulus(1'b0, 8'h04, 0, 32'h4, 1'b0);
        applyStimulus(1'b0, 8'h10, 0, 32'h1D, 1'b0);

        // Software start via CTRL bit1
        applyStimulus(1'b1, 8'h00, 32'h1D, 32'h0, 1'b0);
        step(1);
        applyStimulus(1'b1, 8'h00, 32'h1F, 32'h0, 1'b0);
        checkOutput("sw_start trace_enable", 32'(traceEnable), 32'h1);
        applyStimulus(1'b0, 8'h00, 0, 32'h1D, 1'b0);
        applyStimulus(1'b0, 8'h08, 0, 32'h4, 1'b0);
        applyStimulus(1'b1, 8'h08, 32'h0, 32'h0, 1'b0);
        applyStimulus(1'b0, 8'h08, 0, 32'h0, 1'b0);
        pulse(2'b00, 2'b01);
        step(4);
        applyStimulus(1'b0, 8'h04, 0, 32'hD, 1'b0);
        applyStimulus(1'b1, 8'h04, 32'hC, 32'h0, 1'b0);

        // ON_COUNT saturation
        force dut.g_ch[0].r_on_count = 16'hFFFE;
        @(negedge clk);
        release dut.g_ch[0].r_on_count;
        @(posedge clk); #1;
        applyStimulus(1'b0, 8'h08, 0, 32'hFFFE, 1'b0);
        pulse(2'b01, 2'b00);
        applyStimulus(1'b0, 8'h08, 0, 32'hFFFF, 1'b0);
        pulse(2'b00, 2'b01);
        step(4);
        pulse(2'b01, 2'b00);
        applyStimulus(1'b0, 8'h08, 0, 32'hFFFF, 1'b0);

        // Asynchronous reset while tracing
        checkOutput("pre-reset trace_enable", 32'(traceEnable), 32'h1);
        step(1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset trace_enable", 32'(traceEnable), 32'h0);
        checkOutput("async reset clk_en", 32'(clkEn), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        applyStimulus(1'b0, 8'h08, 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 8'h00, 0, 32'h1D, 1'b0);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) step(1);
        if (expQ.size() > 0)
            checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/trdb_ctrl_regs.md
# trdb_ctrl_regs

Multi-channel control and status register block for the trace encoder. It holds per-channel packet-emitter settings in memory-mapped registers behind a simple single-cycle bus. Each channel runs a trace-enable state machine driven by the trigger-unit on/off requests, with a drain window that keeps the channel's clock enable alive after tracing stops. It sits between the debug bus / trigger unit and the per-hart encoder instances, and drives their configuration and clock-gate enables.

## Interface
- NCH, 2: number of trace channels (harts), ≥1
- ADDR_W, 8: bus address width, ≥ 4+$clog2(NCH)
- DRAIN_CYCLES, 4: cycles clk_en_o stays high after trace_enable_o drops, ≥1
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- req_i  in  1  bus request, one transfer per asserted cycle
- we_i  in  1  1=write, 0=read
- addr_i  in  ADDR_W  byte address; [ADDR_W-1:4]=channel, [3:2]=register, [1:0] ignored
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid, one cycle after req_i
- rdata_o  out  32  read data (0 on writes and errors)
- err_o  out  1  qualified by rvalid_o; channel ≥ NCH or register index 3
- trace_req_on_i  in  NCH  per-channel trigger start request
- trace_req_off_i  in  NCH  per-channel stop request (from filter)
- trace_enable_o  out  NCH  channel in TRACING
- trace_activated_o  out  NCH  CTRL.activate
- clk_en_o  out  NCH  clock-gate enable; state ≠ IDLE
- nocontext_o, notime_o  out  NCH each  CTRL bits
- delta_address_o  out  NCH  CTRL.delta & ~CTRL.full
- full_address_o  out  NCH  CTRL.full
- encoder_mode_o  out  1  hardwired 0

## Operation
- Per channel, offset 0x0 CTRL (RW): bit0 activate, bit1 sw_start (write-only pulse, reads 0), bit2 nocontext, bit3 notime, bit4 delta, bit5 full; other bits read 0. Reset 0x1D.
- Offset 0x4 STATUS: [1:0] state (IDLE=0, ARMED=1, TRACING=2, DRAIN=3, RO); bit2 on_seen and bit3 off_seen are sticky and write-1-to-clear. Set and clear in the same cycle: set wins.
- Offset 0x8 ON_COUNT (RO, write clears): bits[15:0] count ARMED→TRACING transitions, saturating at 0xFFFF.
- on_eff = trace_req_on_i[c] | sw_start pulse; on_seen sets on on_eff, off_seen on trace_req_off_i[c].
- FSM per channel:
  - IDLE→ARMED when activate=1.
  - ARMED→TRACING on on_eff & ~off; on+off together stays ARMED; ARMED→IDLE if activate=0.
  - TRACING→DRAIN on off or activate=0; off wins over simultaneous on.
  - DRAIN loads counter DRAIN_CYCLES-1 and decrements. At 0 it goes to ARMED if activate=1, else IDLE. Requests are ignored in DRAIN.
- Triggers are evaluated against the CTRL value held before a same-cycle register write.
- Reset: all CTRL=0x1D, STATUS sticky bits 0, ON_COUNT 0, all FSMs IDLE; outputs follow immediately (trace_enable_o=0, clk_en_o=0, rvalid_o=0, err_o=0, rdata_o=0).

## Timing
- Bus: req_i at cycle t → rvalid_o/rdata_o/err_o valid at t+1 for exactly one cycle. Always accepted, no back-pressure. Write effect visible from t+1. Errored writes have no effect.
- FSM leaves IDLE one cycle after activate is 1 (first cycle out of reset, since activate resets to 1).
- on at t in ARMED → trace_enable_o=1 at t+1; ON_COUNT incremented at t+1.
- off at t in TRACING → trace_enable_o=0 at t+1. clk_en_o stays 1 for DRAIN_CYCLES cycles (t+1..t+DRAIN_CYCLES), then reflects the next state.
- Reset asserted mid-TRACING or DRAIN: immediate return to IDLE, with no drain.

## Test plan
- Reset, read CTRL ch0 → 0x1D, err 0. One cycle later, STATUS ch0 state=1 (ARMED).
- Pulse trace_req_on_i[0] at t → trace_enable_o[0]=1 at t+1, ON_COUNT ch0 reads 1, STATUS bit2=1. Write 0x4 to STATUS → bit2 reads 0.
- With DRAIN_CYCLES=4, pulse off at t → trace_enable_o=0 at t+1, clk_en_o=1 through t+4, state ARMED at t+5.
- Assert on and off in the same cycle in ARMED → stays ARMED. In TRACING the same pulse → DRAIN.
- Write CTRL=0x30 → delta_address_o=0, full_address_o=1. A TRACING channel drains, then goes to IDLE, with clk_en_o=0 after the drain.
- Access channel NCH and offset 0xC → err_o=1, rdata_o=0, no state change. Force ON_COUNT to 0xFFFF plus one more start → stays 0xFFFF.
